traffic_seq: RTL and testbench



---
 rtl/traffic_seq.sv | 83 ++++++++
 tb/tb_traffic_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/traffic_seq.sv
// Phase sequencer for a two-road traffic light: times each phase with a counter
// and steps idle -> r2 green -> r2 yellow -> r1 green -> r1 yellow -> r2 green ...
module traffic_seq #(
  parameter int SIZE       = 3,   // phase code width; the encoding below needs 3
  parameter int GREEN_CYC  = 30,
  parameter int YELLOW_CYC = 5,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             rstc,
  input  logic             select,
  output logic [SIZE-1:0]  Q,
  output logic [CNT_W-1:0] count,
  output logic             phase_end
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    R2_GREEN  = 3'b001,
    R2_YELLOW = 3'b010,
    R1_GREEN  = 3'b011,
    R1_YELLOW = 3'b100
  } phase_t;

  localparam logic [CNT_W-1:0] GREEN_T  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_CYC - 1);

  logic [SIZE-1:0]  q_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] term;
  logic             legal;
  logic             at_term;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q     <= IDLE;
      count <= '0;
    end else begin
      Q     <= q_nxt;
      count <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    q_nxt     = Q;
    cnt_nxt   = count;
    term      = select ? YELLOW_T : GREEN_T;
    legal     = (Q <= SIZE'(R1_YELLOW));
    at_term   = (count == term);
    phase_end = !rstc && !hold && !stop && at_term && legal;

    if (!legal || stop) begin
      q_nxt   = IDLE;
      cnt_nxt = '0;
    end else if (!hold) begin
      if (rstc) begin
        cnt_nxt = '0;
        if (start) q_nxt = R2_GREEN;
      end else if (at_term) begin
        cnt_nxt = '0;
        // Yellow of road1 wraps straight back to road2 green, never via idle.
        case (Q)
          R2_GREEN:  q_nxt = R2_YELLOW;
          R2_YELLOW: q_nxt = R1_GREEN;
          R1_GREEN:  q_nxt = R1_YELLOW;
          R1_YELLOW: q_nxt = R2_GREEN;
          default:   q_nxt = IDLE;
        endcase
      end else begin
        cnt_nxt = count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_seq.sv
// Directed scoreboard bench for traffic_seq: one instance with GREEN=4/YELLOW=2
// and one with YELLOW=1, each fed by a behavioural output decoder.
module tb_traffic_seq;

  typedef struct packed {
    logic [2:0] q;
    logic [7:0] c;
    logic       pe;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [2:0] q1, q2;
  logic [7:0] cnt1, cnt2;
  logic       pe1, pe2;
  logic       rstc1, sel1, rstc2, sel2;

  int    tests = 0;
  int    failed = 0;
  string tag = "reset";
  obs_t  exp_q[$];

  always #5 clk = ~clk;

  // Decoder feedback: idle flag and yellow flag derived from the phase code.
  assign rstc1 = (q1 == 3'd0);
  assign sel1  = (q1 == 3'd2) || (q1 == 3'd4);
  assign rstc2 = (q2 == 3'd0);
  assign sel2  = (q2 == 3'd2) || (q2 == 3'd4);

  traffic_seq #(.SIZE(3), .GREEN_CYC(4), .YELLOW_CYC(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .rstc(rstc1), .select(sel1), .Q(q1), .count(cnt1), .phase_end(pe1)
  );

  traffic_seq #(.SIZE(3), .GREEN_CYC(4), .YELLOW_CYC(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .rstc(rstc2), .select(sel2), .Q(q2), .count(cnt2), .phase_end(pe2)
  );

  task automatic compare(input int which);
    obs_t e, g;
    e = exp_q.pop_front();
    g = (which == 1) ? obs_t'{q2, cnt2, pe2} : obs_t'{q1, cnt1, pe1};
    tests++;
    assert (g === e) else begin
      failed++;
      $error("FAIL %s#%0d dut%0d: got Q=%0d count=%0d phase_end=%0b, expected Q=%0d count=%0d phase_end=%0b",
             tag, tests, which + 1, g.q, g.c, g.pe, e.q, e.c, e.pe);
    end
  endtask

  // Drive inputs, queue the expected post-edge observation, then check it.
  task automatic step(input logic s, p, h, input int which,
                      input logic [2:0] eq, input logic [7:0] ec, input logic ep);
    start = s; stop = p; hold = h;
    exp_q.push_back('{eq, ec, ep});
    @(posedge clk);
    #1;
    compare(which);
  endtask

  task automatic check_now(input int which,
                           input logic [2:0] eq, input logic [7:0] ec, input logic ep);
    exp_q.push_back('{eq, ec, ep});
    compare(which);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_now(0, 3'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    repeat (10) step(0, 0, 0, 0, 3'd0, 8'd0, 1'b0);

    tag = "cycle";
    step(1, 0, 0, 0, 3'd1, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd2, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd2, 8'd1, 1'b1);
    step(0, 0, 0, 0, 3'd3, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd4, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd4, 8'd1, 1'b1);
    step(0, 0, 0, 0, 3'd1, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd2, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd2, 8'd1, 1'b1);
    step(0, 0, 0, 0, 3'd3, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd2, 1'b0);

    tag = "hold";
    repeat (5) step(0, 0, 1, 0, 3'd3, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd4, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd4, 8'd1, 1'b1);
    tag = "hold_term";
    repeat (2) step(0, 0, 1, 0, 3'd4, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd2, 8'd0, 1'b0);

    tag = "stop";
    step(0, 1, 1, 0, 3'd0, 8'd0, 1'b0);
    repeat (2) step(1, 1, 0, 0, 3'd0, 8'd0, 1'b0);

    tag = "restart";
    step(1, 0, 0, 0, 3'd1, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd2, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd2, 8'd1, 1'b1);
    step(0, 0, 0, 0, 3'd3, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd3, 8'd3, 1'b1);
    step(0, 0, 0, 0, 3'd4, 8'd0, 1'b0);

    tag = "async_rst";
    #2 rst_n = 1'b0;
    #1 check_now(0, 3'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 3'd1, 8'd0, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd1, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd2, 1'b0);
    step(0, 0, 0, 0, 3'd1, 8'd3, 1'b1);

    tag = "illegal";
    force dut.Q = 3'b110;
    #1 check_now(0, 3'd6, 8'd3, 1'b0);
    release dut.Q;
    step(0, 0, 0, 0, 3'd0, 8'd0, 1'b0);

    tag = "yellow1";
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step(1, 0, 0, 1, 3'd1, 8'd0, 1'b0);
    step(0, 0, 0, 1, 3'd1, 8'd1, 1'b0);
    step(0, 0, 0, 1, 3'd1, 8'd2, 1'b0);
    step(0, 0, 0, 1, 3'd1, 8'd3, 1'b1);
    step(0, 0, 0, 1, 3'd2, 8'd0, 1'b1);
    step(0, 0, 0, 1, 3'd3, 8'd0, 1'b0);
    step(0, 0, 0, 1, 3'd3, 8'd1, 1'b0);
    step(0, 0, 0, 1, 3'd3, 8'd2, 1'b0);
    step(0, 0, 0, 1, 3'd3, 8'd3, 1'b1);
    step(0, 0, 0, 1, 3'd4, 8'd0, 1'b1);
    step(0, 0, 0, 1, 3'd1, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
